// File: rtl/vx_bridge_pkg.sv
// Shared types and helpers for the Vortex-to-ESP AXI offset bridge.
// Address-request payload layout, response codes and counter sizing.
package vx_bridge_pkg;

    localparam int BR_ADDR_W = 32;
    localparam int BR_ID_W   = 8;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef struct packed {
        logic [BR_ID_W-1:0]   id;
        logic [BR_ADDR_W-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic                 lock;
        logic [3:0]           cache;
        logic [2:0]           prot;
        logic [3:0]           qos;
    } ax_req_t;

    // One extra bit so the counter can hold MAX_OUTST itself.
    function automatic int outst_cnt_w(input int max_outst);
        return $clog2(max_outst) + 1;
    endfunction

endpackage

// File: rtl/vx_axi_skid.sv
// Two-entry skid buffer with a registered ready. out_en lets the parent
// withhold the head entry (drain / outstanding limit) without popping it.
module vx_axi_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_en,
    input  logic         out_ready,
    output logic         empty_nxt
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         full;
    logic [1:0]   cnt;
    logic [1:0]   cnt_nxt;
    logic         push;
    logic         pop;

    // full is a flop, so ready never depends on the downstream side.
    assign in_ready  = ~full & ~reset;
    assign push      = in_valid & in_ready;
    assign out_valid = (cnt != 2'd0) & out_en;
    assign pop       = out_valid & out_ready;
    assign out_data  = mem[rd_ptr];
    assign cnt_nxt   = cnt + 2'(push) - 2'(pop);
    assign empty_nxt = (cnt_nxt == 2'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= 2'd0;
            full   <= 1'b0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            full <= (cnt_nxt == 2'd2);
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

endmodule

// File: rtl/vx_axi_offset_bridge.sv
// Registered AXI4 bridge: adds base_addr to AW/AR through skid buffers,
// limits outstanding transactions, supports drain, counts error beats.
module vx_axi_offset_bridge
    import vx_bridge_pkg::*;
#(
    parameter int ADDR_W    = BR_ADDR_W,
    parameter int DATA_W    = 512,
    parameter int ID_W      = BR_ID_W,
    parameter int MAX_OUTST = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic                drain,
    output logic                idle,
    output logic [15:0]         err_cnt,

    input  logic [ID_W-1:0]     s_axi_awid,
    input  logic [ADDR_W-1:0]   s_axi_awaddr,
    input  logic [7:0]          s_axi_awlen,
    input  logic [2:0]          s_axi_awsize,
    input  logic [1:0]          s_axi_awburst,
    input  logic                s_axi_awlock,
    input  logic [3:0]          s_axi_awcache,
    input  logic [2:0]          s_axi_awprot,
    input  logic [3:0]          s_axi_awqos,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,

    input  logic [ID_W-1:0]     s_axi_arid,
    input  logic [ADDR_W-1:0]   s_axi_araddr,
    input  logic [7:0]          s_axi_arlen,
    input  logic [2:0]          s_axi_arsize,
    input  logic [1:0]          s_axi_arburst,
    input  logic                s_axi_arlock,
    input  logic [3:0]          s_axi_arcache,
    input  logic [2:0]          s_axi_arprot,
    input  logic [3:0]          s_axi_arqos,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,

    output logic [ID_W-1:0]     m_axi_awid,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic [7:0]          m_axi_awlen,
    output logic [2:0]          m_axi_awsize,
    output logic [1:0]          m_axi_awburst,
    output logic                m_axi_awlock,
    output logic [3:0]          m_axi_awcache,
    output logic [2:0]          m_axi_awprot,
    output logic [3:0]          m_axi_awqos,
    output logic [5:0]          m_axi_awatop,
    output logic [3:0]          m_axi_awregion,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,

    output logic [ID_W-1:0]     m_axi_arid,
    output logic [ADDR_W-1:0]   m_axi_araddr,
    output logic [7:0]          m_axi_arlen,
    output logic [2:0]          m_axi_arsize,
    output logic [1:0]          m_axi_arburst,
    output logic                m_axi_arlock,
    output logic [3:0]          m_axi_arcache,
    output logic [2:0]          m_axi_arprot,
    output logic [3:0]          m_axi_arqos,
    output logic [3:0]          m_axi_arregion,
    output logic                m_axi_arvalid,
    input  logic                m_axi_arready,

    input  logic [DATA_W-1:0]   s_axi_wdata,
    input  logic [DATA_W/8-1:0] s_axi_wstrb,
    input  logic                s_axi_wlast,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic                m_axi_wlast,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,

    input  logic [ID_W-1:0]     m_axi_bid,
    input  logic [1:0]          m_axi_bresp,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,
    output logic [ID_W-1:0]     s_axi_bid,
    output logic [1:0]          s_axi_bresp,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,

    input  logic [ID_W-1:0]     m_axi_rid,
    input  logic [DATA_W-1:0]   m_axi_rdata,
    input  logic [1:0]          m_axi_rresp,
    input  logic                m_axi_rlast,
    input  logic                m_axi_rvalid,
    output logic                m_axi_rready,
    output logic [ID_W-1:0]     s_axi_rid,
    output logic [DATA_W-1:0]   s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic                s_axi_rlast,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready
);

    localparam int             CW      = outst_cnt_w(MAX_OUTST);
    localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_OUTST);
    localparam int             REQ_W   = $bits(ax_req_t);

    // The request payload type is fixed by the package widths.
    if (ADDR_W != BR_ADDR_W || ID_W != BR_ID_W) begin : g_cfg_check
        $error("vx_axi_offset_bridge: ADDR_W/ID_W must match vx_bridge_pkg");
    end

    ax_req_t       aw_in, aw_out, ar_in, ar_out;
    logic          aw_en, ar_en, aw_hold, ar_hold;
    logic          aw_empty_nxt, ar_empty_nxt;
    logic          aw_hs, ar_hs, b_hs, r_last_hs, b_err, r_err;
    logic [CW-1:0] wr_out, rd_out, wr_nxt, rd_nxt;
    logic [16:0]   err_sum;

    always_comb begin
        aw_in = '{id: s_axi_awid, addr: s_axi_awaddr + base_addr, len: s_axi_awlen,
                  size: s_axi_awsize, burst: s_axi_awburst, lock: s_axi_awlock,
                  cache: s_axi_awcache, prot: s_axi_awprot, qos: s_axi_awqos};
        ar_in = '{id: s_axi_arid, addr: s_axi_araddr + base_addr, len: s_axi_arlen,
                  size: s_axi_arsize, burst: s_axi_arburst, lock: s_axi_arlock,
                  cache: s_axi_arcache, prot: s_axi_arprot, qos: s_axi_arqos};
    end

    // A head that was already presented stays valid until it is taken.
    assign aw_en = aw_hold | (~drain & (wr_out < CNT_MAX));
    assign ar_en = ar_hold | (~drain & (rd_out < CNT_MAX));

    vx_axi_skid #(.W(REQ_W)) u_aw_skid (
        .clk       (clk),
        .reset     (reset),
        .in_data   (aw_in),
        .in_valid  (s_axi_awvalid),
        .in_ready  (s_axi_awready),
        .out_data  (aw_out),
        .out_valid (m_axi_awvalid),
        .out_en    (aw_en),
        .out_ready (m_axi_awready),
        .empty_nxt (aw_empty_nxt)
    );

    vx_axi_skid #(.W(REQ_W)) u_ar_skid (
        .clk       (clk),
        .reset     (reset),
        .in_data   (ar_in),
        .in_valid  (s_axi_arvalid),
        .in_ready  (s_axi_arready),
        .out_data  (ar_out),
        .out_valid (m_axi_arvalid),
        .out_en    (ar_en),
        .out_ready (m_axi_arready),
        .empty_nxt (ar_empty_nxt)
    );

    assign m_axi_awid     = aw_out.id;
    assign m_axi_awaddr   = aw_out.addr;
    assign m_axi_awlen    = aw_out.len;
    assign m_axi_awsize   = aw_out.size;
    assign m_axi_awburst  = aw_out.burst;
    assign m_axi_awlock   = aw_out.lock;
    assign m_axi_awcache  = aw_out.cache;
    assign m_axi_awprot   = aw_out.prot;
    assign m_axi_awqos    = aw_out.qos;
    assign m_axi_awatop   = '0;
    assign m_axi_awregion = '0;

    assign m_axi_arid     = ar_out.id;
    assign m_axi_araddr   = ar_out.addr;
    assign m_axi_arlen    = ar_out.len;
    assign m_axi_arsize   = ar_out.size;
    assign m_axi_arburst  = ar_out.burst;
    assign m_axi_arlock   = ar_out.lock;
    assign m_axi_arcache  = ar_out.cache;
    assign m_axi_arprot   = ar_out.prot;
    assign m_axi_arqos    = ar_out.qos;
    assign m_axi_arregion = '0;

    assign m_axi_wdata  = s_axi_wdata;
    assign m_axi_wstrb  = s_axi_wstrb;
    assign m_axi_wlast  = s_axi_wlast;
    assign m_axi_wvalid = s_axi_wvalid;
    assign s_axi_wready = m_axi_wready;

    assign s_axi_bid    = m_axi_bid;
    assign s_axi_bresp  = m_axi_bresp;
    assign s_axi_bvalid = m_axi_bvalid;
    assign m_axi_bready = s_axi_bready;

    assign s_axi_rid    = m_axi_rid;
    assign s_axi_rdata  = m_axi_rdata;
    assign s_axi_rresp  = m_axi_rresp;
    assign s_axi_rlast  = m_axi_rlast;
    assign s_axi_rvalid = m_axi_rvalid;
    assign m_axi_rready = s_axi_rready;

    assign aw_hs     = m_axi_awvalid & m_axi_awready;
    assign ar_hs     = m_axi_arvalid & m_axi_arready;
    assign b_hs      = m_axi_bvalid & s_axi_bready;
    assign r_last_hs = m_axi_rvalid & s_axi_rready & m_axi_rlast;
    assign b_err     = b_hs & (m_axi_bresp != AXI_RESP_OKAY);
    assign r_err     = m_axi_rvalid & s_axi_rready & (m_axi_rresp != AXI_RESP_OKAY);

    assign wr_nxt  = wr_out + CW'(aw_hs) - CW'(b_hs);
    assign rd_nxt  = rd_out + CW'(ar_hs) - CW'(r_last_hs);
    assign err_sum = {1'b0, err_cnt} + 17'(b_err) + 17'(r_err);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_out  <= '0;
            rd_out  <= '0;
            aw_hold <= 1'b0;
            ar_hold <= 1'b0;
            err_cnt <= '0;
            idle    <= 1'b1;
        end else begin
            wr_out  <= wr_nxt;
            rd_out  <= rd_nxt;
            aw_hold <= m_axi_awvalid & ~m_axi_awready;
            ar_hold <= m_axi_arvalid & ~m_axi_arready;
            err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
            // Built from next state so idle drops the cycle after the first accept.
            idle    <= aw_empty_nxt & ar_empty_nxt & (wr_nxt == '0) & (rd_nxt == '0);
        end
    end

    a_wr_underflow: assert property (@(posedge clk) disable iff (reset)
        !(b_hs && !aw_hs && wr_out == '0));
    a_rd_underflow: assert property (@(posedge clk) disable iff (reset)
        !(r_last_hs && !ar_hs && rd_out == '0));

endmodule

// File: tb/tb_vx_axi_offset_bridge.sv
// Directed bench for vx_axi_offset_bridge: offset add, throttle, drain,
// counter cancellation, error saturation and reset behaviour.
module tb_vx_axi_offset_bridge;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 512;
    localparam int ID_W   = 8;

    logic                clk = 1'b0;
    logic                reset;
    logic [ADDR_W-1:0]   base_addr;
    logic                drain;
    logic                idle;
    logic [15:0]         err_cnt;

    logic [ID_W-1:0]     s_axi_awid, s_axi_arid, m_axi_awid, m_axi_arid;
    logic [ADDR_W-1:0]   s_axi_awaddr, s_axi_araddr, m_axi_awaddr, m_axi_araddr;
    logic [7:0]          s_axi_awlen, s_axi_arlen, m_axi_awlen, m_axi_arlen;
    logic [2:0]          s_axi_awsize, s_axi_arsize, m_axi_awsize, m_axi_arsize;
    logic [1:0]          s_axi_awburst, s_axi_arburst, m_axi_awburst, m_axi_arburst;
    logic                s_axi_awlock, s_axi_arlock, m_axi_awlock, m_axi_arlock;
    logic [3:0]          s_axi_awcache, s_axi_arcache, m_axi_awcache, m_axi_arcache;
    logic [2:0]          s_axi_awprot, s_axi_arprot, m_axi_awprot, m_axi_arprot;
    logic [3:0]          s_axi_awqos, s_axi_arqos, m_axi_awqos, m_axi_arqos;
    logic                s_axi_awvalid, s_axi_arvalid, m_axi_awvalid, m_axi_arvalid;
    logic                s_axi_awready, s_axi_arready, m_axi_awready, m_axi_arready;
    logic [5:0]          m_axi_awatop;
    logic [3:0]          m_axi_awregion, m_axi_arregion;

    logic [DATA_W-1:0]   s_axi_wdata, m_axi_wdata;
    logic [DATA_W/8-1:0] s_axi_wstrb, m_axi_wstrb;
    logic                s_axi_wlast, m_axi_wlast, s_axi_wvalid, m_axi_wvalid;
    logic                s_axi_wready, m_axi_wready;

    logic [ID_W-1:0]     m_axi_bid, s_axi_bid;
    logic [1:0]          m_axi_bresp, s_axi_bresp;
    logic                m_axi_bvalid, s_axi_bvalid, m_axi_bready, s_axi_bready;

    logic [ID_W-1:0]     m_axi_rid, s_axi_rid;
    logic [DATA_W-1:0]   m_axi_rdata, s_axi_rdata;
    logic [1:0]          m_axi_rresp, s_axi_rresp;
    logic                m_axi_rlast, s_axi_rlast, m_axi_rvalid, s_axi_rvalid;
    logic                m_axi_rready, s_axi_rready;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vx_axi_offset_bridge #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .MAX_OUTST(16)
    ) dut (
        .clk(clk), .reset(reset), .base_addr(base_addr), .drain(drain),
        .idle(idle), .err_cnt(err_cnt),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock),
        .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot), .s_axi_awqos(s_axi_awqos),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock),
        .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot), .s_axi_arqos(s_axi_arqos),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
        .m_axi_awatop(m_axi_awatop), .m_axi_awregion(m_axi_awregion),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
        .m_axi_arregion(m_axi_arregion),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic init_inputs;
        reset = 1'b1; base_addr = '0; drain = 1'b0;
        s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = 3'd6;
        s_axi_awburst = 2'd1; s_axi_awlock = 1'b0; s_axi_awcache = '0; s_axi_awprot = '0;
        s_axi_awqos = '0; s_axi_awvalid = 1'b0;
        s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = 3'd6;
        s_axi_arburst = 2'd1; s_axi_arlock = 1'b0; s_axi_arcache = '0; s_axi_arprot = '0;
        s_axi_arqos = '0; s_axi_arvalid = 1'b0;
        m_axi_awready = 1'b1; m_axi_arready = 1'b1;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
        m_axi_wready = 1'b0;
        m_axi_bid = '0; m_axi_bresp = 2'd0; m_axi_bvalid = 1'b0; s_axi_bready = 1'b1;
        m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = 2'd0; m_axi_rlast = 1'b0;
        m_axi_rvalid = 1'b0; s_axi_rready = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick; tick;
        total++; if (s_axi_awready !== 1'b0) begin bad++; $display("FAIL rst_awready: got %b want 0", s_axi_awready); end
        total++; if (s_axi_arready !== 1'b0) begin bad++; $display("FAIL rst_arready: got %b want 0", s_axi_arready); end
        total++; if ({m_axi_awvalid, m_axi_arvalid} !== 2'b00) begin bad++; $display("FAIL rst_mvalid: got %b want 00", {m_axi_awvalid, m_axi_arvalid}); end
        total++; if (idle !== 1'b1 || err_cnt !== 16'h0) begin bad++; $display("FAIL rst_idle_err: got idle=%b err=%h want 1/0000", idle, err_cnt); end
        reset = 1'b0;
        tick;
        total++; if ({s_axi_awready, s_axi_arready} !== 2'b11) begin bad++; $display("FAIL post_rst_ready: got %b want 11", {s_axi_awready, s_axi_arready}); end
        total++; if (m_axi_awatop !== 6'd0 || m_axi_awregion !== 4'd0 || m_axi_arregion !== 4'd0) begin bad++; $display("FAIL tied_zero: got %h %h %h want 0", m_axi_awatop, m_axi_awregion, m_axi_arregion); end
    endtask

    task automatic test_single_read;
        base_addr = 32'h8000_0000;
        s_axi_arid = 8'h05; s_axi_araddr = 32'h0000_1040; s_axi_arlen = 8'd3; s_axi_arvalid = 1'b1;
        #1;
        total++; if (m_axi_arvalid !== 1'b0) begin bad++; $display("FAIL rd_latency: got arvalid=%b want 0", m_axi_arvalid); end
        tick;
        s_axi_arvalid = 1'b0;
        total++; if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== 32'h8000_1040) begin bad++; $display("FAIL rd_addr: got v=%b addr=%h want 1/80001040", m_axi_arvalid, m_axi_araddr); end
        total++; if (m_axi_arlen !== 8'd3 || m_axi_arid !== 8'h05) begin bad++; $display("FAIL rd_fields: got len=%0d id=%h want 3/05", m_axi_arlen, m_axi_arid); end
        total++; if (idle !== 1'b0) begin bad++; $display("FAIL rd_idle_drop: got %b want 0", idle); end
        tick;
        total++; if (dut.rd_out !== 5'd1 || m_axi_arvalid !== 1'b0) begin bad++; $display("FAIL rd_issued: got rd_out=%0d v=%b want 1/0", dut.rd_out, m_axi_arvalid); end
        for (int i = 0; i < 4; i++) begin
            m_axi_rvalid = 1'b1; m_axi_rid = 8'h05; m_axi_rdata = DATA_W'(32'hA000 + i); m_axi_rlast = (i == 3);
            #1;
            if (i == 0) begin
                total++; if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== DATA_W'(32'hA000)) begin bad++; $display("FAIL r_pass: got v=%b data=%h want 1/a000", s_axi_rvalid, s_axi_rdata[31:0]); end
            end
            tick;
            if (i == 2) begin
                total++; if (idle !== 1'b0) begin bad++; $display("FAIL rd_idle_mid: got %b want 0", idle); end
            end
        end
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL rd_idle_back: got %b want 1", idle); end
    endtask

    task automatic test_wrap;
        base_addr = 32'hFFFF_FF00;
        m_axi_awready = 1'b0;
        s_axi_awaddr = 32'h0000_0200; s_axi_awvalid = 1'b1;
        tick;
        s_axi_awvalid = 1'b0;
        total++; if (m_axi_awvalid !== 1'b1 || m_axi_awaddr !== 32'h0000_0100) begin bad++; $display("FAIL wrap_addr: got v=%b addr=%h want 1/00000100", m_axi_awvalid, m_axi_awaddr); end
        base_addr = 32'h0000_1000;
        tick;
        total++; if (m_axi_awaddr !== 32'h0000_0100) begin bad++; $display("FAIL base_kept: got %h want 00000100", m_axi_awaddr); end
        m_axi_awready = 1'b1; s_axi_awvalid = 1'b1;
        tick;
        s_axi_awvalid = 1'b0;
        total++; if (m_axi_awvalid !== 1'b1 || m_axi_awaddr !== 32'h0000_1200) begin bad++; $display("FAIL base_new: got v=%b addr=%h want 1/00001200", m_axi_awvalid, m_axi_awaddr); end
        tick;
        m_axi_bvalid = 1'b1;
        tick; tick;
        m_axi_bvalid = 1'b0;
        total++; if (idle !== 1'b1 || dut.wr_out !== 5'd0) begin bad++; $display("FAIL wrap_idle: got idle=%b wr=%0d want 1/0", idle, dut.wr_out); end
    endtask

    task automatic test_throttle;
        int acc, hs;
        acc = 0; hs = 0;
        base_addr = '0;
        s_axi_awvalid = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (s_axi_awvalid && s_axi_awready) acc++;
            if (m_axi_awvalid && m_axi_awready) hs++;
            if (acc == 20) s_axi_awvalid = 1'b0;
            tick;
        end
        s_axi_awvalid = 1'b0;
        total++; if (hs !== 16 || acc !== 18) begin bad++; $display("FAIL throttle_cnt: got hs=%0d acc=%0d want 16/18", hs, acc); end
        total++; if (s_axi_awready !== 1'b0 || m_axi_awvalid !== 1'b0) begin bad++; $display("FAIL throttle_stall: got rdy=%b v=%b want 0/0", s_axi_awready, m_axi_awvalid); end
        m_axi_bvalid = 1'b1;
        tick;
        m_axi_bvalid = 1'b0;
        hs = 0;
        for (int c = 0; c < 5; c++) begin
            if (m_axi_awvalid && m_axi_awready) hs++;
            tick;
        end
        total++; if (hs !== 1 || dut.wr_out !== 5'd16) begin bad++; $display("FAIL throttle_one_b: got hs=%0d wr=%0d want 1/16", hs, dut.wr_out); end
        m_axi_bvalid = 1'b1;
        for (int c = 0; c < 17; c++) tick;
        m_axi_bvalid = 1'b0;
        total++; if (dut.wr_out !== 5'd0 || idle !== 1'b1) begin bad++; $display("FAIL throttle_clean: got wr=%0d idle=%b want 0/1", dut.wr_out, idle); end
    endtask

    task automatic test_drain;
        s_axi_arlen = 8'd0; s_axi_arvalid = 1'b1;
        tick; tick; tick;
        s_axi_arvalid = 1'b0;
        tick;
        total++; if (dut.rd_out !== 5'd3) begin bad++; $display("FAIL drain_setup: got rd=%0d want 3", dut.rd_out); end
        drain = 1'b1;
        s_axi_arvalid = 1'b1;
        tick;
        s_axi_arvalid = 1'b0;
        s_axi_wvalid = 1'b1; s_axi_wdata = DATA_W'(32'h1234_5678); m_axi_wready = 1'b1;
        #1;
        total++; if (m_axi_wvalid !== 1'b1 || m_axi_wdata !== DATA_W'(32'h1234_5678) || s_axi_wready !== 1'b1) begin bad++; $display("FAIL w_pass_drain: got v=%b d=%h r=%b want 1/12345678/1", m_axi_wvalid, m_axi_wdata[31:0], s_axi_wready); end
        for (int c = 0; c < 4; c++) begin
            total++; if (m_axi_arvalid !== 1'b0 || idle !== 1'b0) begin bad++; $display("FAIL drain_block: got v=%b idle=%b want 0/0", m_axi_arvalid, idle); end
            tick;
        end
        s_axi_wvalid = 1'b0; m_axi_wready = 1'b0;
        drain = 1'b0;
        #1;
        total++; if (m_axi_arvalid !== 1'b1) begin bad++; $display("FAIL drain_release: got %b want 1", m_axi_arvalid); end
        tick;
        total++; if (dut.rd_out !== 5'd4) begin bad++; $display("FAIL drain_issued: got %0d want 4", dut.rd_out); end
        m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1;
        tick; tick; tick; tick;
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL drain_idle: got %b want 1", idle); end
        // drain rising after a head is presented must not retract it
        m_axi_arready = 1'b0; s_axi_arvalid = 1'b1;
        tick;
        s_axi_arvalid = 1'b0;
        tick;
        drain = 1'b1;
        #1;
        total++; if (m_axi_arvalid !== 1'b1) begin bad++; $display("FAIL drain_hold: got %b want 1", m_axi_arvalid); end
        m_axi_arready = 1'b1;
        tick;
        total++; if (m_axi_arvalid !== 1'b0 || dut.rd_out !== 5'd1) begin bad++; $display("FAIL drain_hold_hs: got v=%b rd=%0d want 0/1", m_axi_arvalid, dut.rd_out); end
        drain = 1'b0;
        m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1;
        tick;
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_addr;
        base_addr = 32'h1000_0000;
        for (int i = 0; i < 5; i++) begin
            s_axi_araddr = 32'h100 * i; s_axi_arvalid = (i < 4);
            #1;
            if (i > 0) begin
                exp_addr = 32'h1000_0000 + 32'h100 * (i - 1);
                total++; if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== exp_addr) begin bad++; $display("FAIL b2b_%0d: got v=%b addr=%h want 1/%h", i, m_axi_arvalid, m_axi_araddr, exp_addr); end
            end
            tick;
        end
        m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1;
        tick; tick; tick; tick;
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL b2b_idle: got %b want 1", idle); end
    endtask

    task automatic test_simultaneous;
        s_axi_awvalid = 1'b1;
        tick;
        tick;
        s_axi_awvalid = 1'b0;
        total++; if (dut.wr_out !== 5'd1 || m_axi_awvalid !== 1'b1) begin bad++; $display("FAIL simul_setup: got wr=%0d v=%b want 1/1", dut.wr_out, m_axi_awvalid); end
        m_axi_bvalid = 1'b1; m_axi_bresp = 2'd2;
        m_axi_rvalid = 1'b1; m_axi_rresp = 2'd2; m_axi_rlast = 1'b0;
        #1;
        total++; if (s_axi_bresp !== 2'd2 || s_axi_bvalid !== 1'b1) begin bad++; $display("FAIL b_pass: got resp=%0d v=%b want 2/1", s_axi_bresp, s_axi_bvalid); end
        tick;
        m_axi_bvalid = 1'b0; m_axi_bresp = 2'd0;
        total++; if (dut.wr_out !== 5'd1) begin bad++; $display("FAIL simul_cancel: got wr=%0d want 1", dut.wr_out); end
        total++; if (err_cnt !== 16'd2) begin bad++; $display("FAIL err_plus2: got %h want 0002", err_cnt); end
        m_axi_rresp = 2'd3;
        repeat (16'hFFFC) tick;
        total++; if (err_cnt !== 16'hFFFE) begin bad++; $display("FAIL err_preload: got %h want fffe", err_cnt); end
        m_axi_bvalid = 1'b1; m_axi_bresp = 2'd2; m_axi_rresp = 2'd2;
        tick;
        m_axi_bvalid = 1'b0; m_axi_bresp = 2'd0;
        total++; if (err_cnt !== 16'hFFFF || dut.wr_out !== 5'd0) begin bad++; $display("FAIL err_sat: got err=%h wr=%0d want ffff/0", err_cnt, dut.wr_out); end
        tick;
        m_axi_rvalid = 1'b0; m_axi_rresp = 2'd0;
        total++; if (err_cnt !== 16'hFFFF) begin bad++; $display("FAIL err_hold: got %h want ffff", err_cnt); end
    endtask

    task automatic test_reset_mid;
        base_addr = '0;
        m_axi_arready = 1'b1; s_axi_arvalid = 1'b1;
        repeat (6) tick;
        m_axi_arready = 1'b0;
        tick;
        s_axi_arvalid = 1'b0;
        total++; if (dut.rd_out !== 5'd5 || s_axi_arready !== 1'b0) begin bad++; $display("FAIL mid_setup: got rd=%0d rdy=%b want 5/0", dut.rd_out, s_axi_arready); end
        reset = 1'b1;
        tick;
        total++; if (m_axi_arvalid !== 1'b0 || m_axi_awvalid !== 1'b0 || dut.rd_out !== 5'd0 || dut.wr_out !== 5'd0) begin bad++; $display("FAIL mid_clear: got av=%b wv=%b rd=%0d wr=%0d want 0/0/0/0", m_axi_arvalid, m_axi_awvalid, dut.rd_out, dut.wr_out); end
        total++; if (idle !== 1'b1 || err_cnt !== 16'h0) begin bad++; $display("FAIL mid_idle_err: got idle=%b err=%h want 1/0000", idle, err_cnt); end
        reset = 1'b0;
        m_axi_arready = 1'b1;
        tick;
        total++; if (s_axi_arready !== 1'b1 || m_axi_arvalid !== 1'b0) begin bad++; $display("FAIL mid_after: got rdy=%b v=%b want 1/0", s_axi_arready, m_axi_arvalid); end
    endtask

    initial begin
        init_inputs();
        test_reset();
        test_single_read();
        test_wrap();
        test_throttle();
        test_drain();
        test_back_to_back();
        test_simultaneous();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
